// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for the multicycle ARM datapath: sequences each instruction
// through fetch/decode/execute/memory/writeback and decodes ALU control and flag writes.
module multicycle_ctrl_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic [1:0] FlagW,
  output logic       PCS,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [3:0] o_dbg_state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_alu_op;
  logic   w_branch;
  logic   w_regw;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Next-state logic; unused encodings fall back to FETCH
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b01:   w_next = S_MEMADR;
          2'b00:   w_next = Funct[5] ? S_EXECI : S_EXECR;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = S_MEMWB;
      S_EXECR:  w_next = S_ALUWB;
      S_EXECI:  w_next = S_ALUWB;
      default:  w_next = S_FETCH;
    endcase
  end

  // Moore outputs: depend only on the current state
  always_comb begin
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    MemW      = 1'b0;
    w_regw    = 1'b0;
    w_alu_op  = 1'b0;
    w_branch  = 1'b0;
    case (r_state)
      S_FETCH: begin
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD:  AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        w_regw    = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      S_EXECR:  w_alu_op = 1'b1;
      S_EXECI: begin
        ALUSrcB  = 2'b01;
        w_alu_op = 1'b1;
      end
      S_ALUWB:  w_regw = 1'b1;
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        w_branch  = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU decoder: only EXECR/EXECI look at Funct, so FETCH stays IR-independent
  always_comb begin
    ALUControl = 2'b00;
    FlagW      = 2'b00;
    if (w_alu_op) begin
      case (Funct[4:1])
        4'b0100: begin ALUControl = 2'b00; FlagW = {Funct[0], Funct[0]};  end
        4'b0010: begin ALUControl = 2'b01; FlagW = {Funct[0], Funct[0]};  end
        4'b0000: begin ALUControl = 2'b10; FlagW = {Funct[0], 1'b0};      end
        4'b1100: begin ALUControl = 2'b11; FlagW = {Funct[0], 1'b0};      end
        default: begin ALUControl = 2'b00; FlagW = 2'b00;                 end
      endcase
    end
  end

  assign RegW        = w_regw;
  assign PCS         = w_branch | (w_regw & (Rd == 4'b1111));
  assign ImmSrc      = Op;
  assign RegSrc      = {(Op == 2'b01), (Op == 2'b10)};
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: walks each instruction class cycle by
// cycle and compares a packed control vector against hand-written expectations.
module tb_multicycle_ctrl_fsm;

  logic       clk;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [1:0] FlagW;
  logic       PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  logic [3:0] o_dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  multicycle_ctrl_fsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .FlagW(FlagW), .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .o_dbg_state(o_dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [18:0] w_obs;
  assign w_obs = {o_dbg_state, IRWrite, NextPC, AdrSrc, ResultSrc, ALUSrcA,
                  ALUSrcB, ALUControl, FlagW, PCS, RegW, MemW};

  // Field order: state, irw, npc, adr, rs, srca, srcb, aluctl, flagw, pcs, regw, memw
  function automatic logic [18:0] ev(input logic [3:0] st, input logic irw, input logic npc,
                                     input logic adr, input logic [1:0] rs, input logic sa,
                                     input logic [1:0] sb, input logic [1:0] alu,
                                     input logic [1:0] fw, input logic pcs, input logic rw,
                                     input logic mw);
    return {st, irw, npc, adr, rs, sa, sb, alu, fw, pcs, rw, mw};
  endfunction

  task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // Driver: advance one clock and sample just after the edge
  task automatic step_chk(input string tag, input logic [18:0] exp);
    @(posedge clk);
    #1;
    chk(tag, w_obs, exp);
  endtask

  logic [18:0] e_fetch, e_decode, e_memadr, e_memrd, e_memwr;

  initial begin
    e_fetch  = ev(4'd0, 1, 1, 0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 0, 0, 0);
    e_decode = ev(4'd1, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 0, 0, 0);
    e_memadr = ev(4'd2, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0);
    e_memrd  = ev(4'd3, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    e_memwr  = ev(4'd5, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1);

    // Reset state: FETCH outputs even with arbitrary IR fields
    reset = 1'b1; Op = 2'b00; Funct = 6'b000101; Rd = 4'hF;
    #1;
    chk("reset_fetch", w_obs, e_fetch);
    @(negedge clk);
    reset = 1'b0;

    // LDR Rd=2, interrupted in MEMRD by an asynchronous reset
    Op = 2'b01; Funct = 6'b011001; Rd = 4'd2;
    #1;
    chk("ldr_fetch", w_obs, e_fetch);
    chk2("ldr_immsrc", ImmSrc, 2'b01);
    chk2("ldr_regsrc", RegSrc, 2'b10);
    step_chk("ldr_decode", e_decode);
    step_chk("ldr_memadr", e_memadr);
    step_chk("ldr_memrd", e_memrd);
    #2 reset = 1'b1;
    #1;
    chk("async_reset", w_obs, e_fetch);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_release", w_obs, e_fetch);
    step_chk("rst_decode", e_decode);
    step_chk("rst_memadr", e_memadr);
    step_chk("rst_memrd", e_memrd);
    step_chk("ldr_memwb", ev(4'd4, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0));
    step_chk("ldr_done", e_fetch);

    // LDR to R15: writeback raises PCS
    Rd = 4'hF;
    step_chk("ldrpc_decode", e_decode);
    step_chk("ldrpc_memadr", e_memadr);
    step_chk("ldrpc_memrd", e_memrd);
    step_chk("ldrpc_memwb", ev(4'd4, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 2'b00, 1, 1, 0));
    step_chk("ldrpc_done", e_fetch);

    // STR: 4 cycles, MemW only in MEMWR
    Op = 2'b01; Funct = 6'b011000; Rd = 4'd5;
    step_chk("str_decode", e_decode);
    step_chk("str_memadr", e_memadr);
    step_chk("str_memwr", e_memwr);
    step_chk("str_done", e_fetch);

    // SUBS register form, Rd=3
    Op = 2'b00; Funct = 6'b000101; Rd = 4'd3;
    step_chk("subs_decode", e_decode);
    step_chk("subs_execr", ev(4'd6, 0, 0, 0, 2'b00, 0, 2'b00, 2'b01, 2'b11, 0, 0, 0));
    step_chk("subs_aluwb", ev(4'd8, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0));
    step_chk("subs_done", e_fetch);

    // ORRS immediate form, Rd=15
    Op = 2'b00; Funct = 6'b111001; Rd = 4'hF;
    step_chk("orrs_decode", e_decode);
    step_chk("orrs_execi", ev(4'd7, 0, 0, 0, 2'b00, 0, 2'b01, 2'b11, 2'b10, 0, 0, 0));
    step_chk("orrs_aluwb", ev(4'd8, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 1, 1, 0));
    step_chk("orrs_done", e_fetch);

    // ANDS register, ADDS register, ADD immediate without S, unsupported cmd
    Op = 2'b00; Funct = 6'b000001; Rd = 4'd1;
    step_chk("ands_decode", e_decode);
    step_chk("ands_execr", ev(4'd6, 0, 0, 0, 2'b00, 0, 2'b00, 2'b10, 2'b10, 0, 0, 0));
    step_chk("ands_aluwb", ev(4'd8, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0));
    step_chk("ands_done", e_fetch);
    Funct = 6'b001001;
    step_chk("adds_decode", e_decode);
    step_chk("adds_execr", ev(4'd6, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b11, 0, 0, 0));
    step_chk("adds_aluwb", ev(4'd8, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0));
    step_chk("adds_done", e_fetch);
    Funct = 6'b101000;
    step_chk("addi_decode", e_decode);
    step_chk("addi_execi", ev(4'd7, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0));
    step_chk("addi_aluwb", ev(4'd8, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0));
    step_chk("addi_done", e_fetch);
    Funct = 6'b000111;
    step_chk("badcmd_decode", e_decode);
    step_chk("badcmd_execr", ev(4'd6, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0));
    step_chk("badcmd_aluwb", ev(4'd8, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0));
    step_chk("badcmd_done", e_fetch);

    // B: 3 cycles
    Op = 2'b10; Funct = 6'b100000; Rd = 4'd0;
    #1;
    chk2("b_immsrc", ImmSrc, 2'b10);
    chk2("b_regsrc", RegSrc, 2'b01);
    step_chk("b_decode", e_decode);
    step_chk("b_branch", ev(4'd9, 0, 0, 0, 2'b10, 0, 2'b01, 2'b00, 2'b00, 1, 0, 0));
    step_chk("b_done", e_fetch);

    // Undefined: DECODE then straight back to FETCH
    Op = 2'b11; Funct = 6'b001001; Rd = 4'hF;
    #1;
    chk2("undef_regsrc", RegSrc, 2'b00);
    step_chk("undef_decode", e_decode);
    step_chk("undef_done", e_fetch);
    step_chk("undef_next_decode", e_decode);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
